// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: bubble encoding, reset PC
// and the fetch request FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry {instr, pc} holding register that parks a fetch response
// while decode is stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] wr_instr,
  input  logic [31:0] wr_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Clear wins over load so a kill can never leave a stale entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: fetch PC, single-outstanding instruction memory
// requests, skid buffer for stalled responses and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_f, pc_req;
  logic         kill, rsp_live, issue;
  logic         buf_valid, buf_load, buf_clear;
  logic [31:0]  buf_instr, buf_pc;

  assign kill     = PCSrcE | FlushD;
  assign rsp_live = (state == WAIT) && imem_rvalid;

  // A live response under stall goes to the skid buffer, so no new
  // request may be issued in that cycle.
  always_comb begin
    issue = 1'b0;
    if (!rst && (state == IDLE || imem_rvalid) && !kill && !buf_valid
        && !(rsp_live && StallD))
      issue = 1'b1;
  end

  assign imem_req  = issue;
  assign imem_addr = pc_f;

  always_comb begin
    state_next = state;
    if (kill) begin
      if (state != IDLE && !imem_rvalid) state_next = WAIT_KILL;
      else                               state_next = IDLE;
    end else if (issue) begin
      state_next = WAIT;
    end else if (imem_rvalid) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      pc_req <= '0;
    end else if (PCSrcE) begin
      pc_f <= PCTargetE;
    end else if (issue) begin
      pc_req <= pc_f;
      pc_f   <= pc_f + 32'd4;
    end
  end

  assign buf_load  = rsp_live && StallD && !kill;
  assign buf_clear = kill || (buf_valid && !StallD);

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .wr_instr (imem_rdata),
    .wr_pc    (pc_req),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );

  // A redirect without flush still discards the buffered and arriving
  // words, since both are younger than the mispredicted path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (PCSrcE) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (buf_valid) begin
      InstrD   <= buf_instr;
      PCD      <= buf_pc;
      PCPlus4D <= buf_pc + 32'd4;
      ValidD   <= 1'b1;
    end else if (rsp_live) begin
      InstrD   <= imem_rdata;
      PCD      <= pc_req;
      PCPlus4D <= pc_req + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency instruction
// memory whose words are derived from the request address.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req, imem_rvalid, StallD, FlushD, PCSrcE, ValidD;
  logic [31:0] imem_addr, imem_rdata, PCTargetE, InstrD, PCD, PCPlus4D;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned lat    = 1;
  int unsigned m_cnt;
  logic [31:0] m_addr;
  logic        may_resp;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory answers lat cycles after the request edge.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 0;
    else if (imem_req) begin
      m_addr <= imem_addr;
      m_cnt  <= lat;
    end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
  end
  assign imem_rvalid = (m_cnt == 1);
  assign imem_rdata  = word(m_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) may_resp <= 1'b0;
    else if (imem_req) may_resp <= 1'b1;
    else if (imem_rvalid) may_resp <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle, drive inputs, then settle at the falling edge.
  task automatic next(input logic s, input logic f, input logic p, input logic [31:0] t);
    @(posedge clk);
    #1;
    StallD = s; FlushD = f; PCSrcE = p; PCTargetE = t;
    @(negedge clk);
    if (imem_rvalid) chk("rvalid_only_when_outstanding", {31'd0, may_resp}, 32'd1);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, ValidD}, 32'd1);
    chk({tag, "_pcd"}, PCD, pc);
    chk({tag, "_pcplus4"}, PCPlus4D, pc + 32'd4);
    chk({tag, "_instr"}, InstrD, word(pc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_instr"}, InstrD, NOP);
    chk({tag, "_pcd"}, PCD, 32'd0);
    chk({tag, "_pcplus4"}, PCPlus4D, 32'd0);
    chk({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");

    // Zero-wait stream: one request per cycle, ValidD from cycle 2.
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk_req("c0", 32'h0);
    next(0, 0, 0, 0); chk_req("c1", 32'h4);
    next(0, 0, 0, 0); chk_req("c2", 32'h8);  chk_d("c2", 32'h0);
    next(0, 0, 0, 0); chk_req("c3", 32'hC);  chk_d("c3", 32'h4);
    next(0, 0, 0, 0); chk_req("c4", 32'h10);

    // Stall while the 0x10 response arrives: it parks in the skid buffer.
    next(1, 0, 0, 0); chk("c5_req", {31'd0, imem_req}, 32'd0); chk_d("c5_hold", 32'hC);
    next(1, 0, 0, 0); chk("c6_req", {31'd0, imem_req}, 32'd0); chk_d("c6_hold", 32'hC);
    next(1, 0, 0, 0); chk("c7_req", {31'd0, imem_req}, 32'd0);
    next(0, 0, 0, 0); chk("c8_req_buf_full", {31'd0, imem_req}, 32'd0);
    next(0, 0, 0, 0); chk_req("c9", 32'h14); chk_d("c9_from_buf", 32'h10);
    next(0, 0, 0, 0); chk_req("c10", 32'h18);
    chk("c10_bubble", {31'd0, ValidD}, 32'd0);
    lat = 3;

    // Redirect to 0x200 while 0x18 is in flight on slow memory.
    next(0, 0, 1, 32'h200); chk("c11_req", {31'd0, imem_req}, 32'd0); chk_d("c11", 32'h14);
    next(0, 0, 0, 0); chk("c12_req", {31'd0, imem_req}, 32'd0);
    chk("c12_valid", {31'd0, ValidD}, 32'd0);
    next(0, 0, 0, 0); chk_req("c13", 32'h200);
    chk("c13_dropped", {31'd0, ValidD}, 32'd0);
    next(0, 0, 0, 0); chk("c14_req", {31'd0, imem_req}, 32'd0);
    next(0, 0, 0, 0); chk("c15_req", {31'd0, imem_req}, 32'd0);
    next(0, 0, 0, 0); chk_req("c16", 32'h204);
    lat = 1;
    next(0, 0, 0, 0); chk_req("c17", 32'h208); chk_d("c17", 32'h200);

    // Flush+redirect coinciding with a response under stall.
    next(1, 1, 1, 32'h300); chk("c18_req", {31'd0, imem_req}, 32'd0); chk_d("c18", 32'h204);
    next(0, 0, 0, 0); chk_req("c19", 32'h300);
    chk("c19_flushed", {31'd0, ValidD}, 32'd0);

    // Buffer holds 0x300, then flush+redirect discards it.
    next(1, 0, 0, 0); chk("c20_req", {31'd0, imem_req}, 32'd0);
    next(1, 1, 1, 32'hFFFF_FFFC); chk("c21_req", {31'd0, imem_req}, 32'd0);
    next(0, 0, 0, 0); chk_req("c22", 32'hFFFF_FFFC);
    chk("c22_buf_dropped", {31'd0, ValidD}, 32'd0);
    next(0, 0, 0, 0); chk_req("c23_wrap", 32'h0);
    chk("c23_valid", {31'd0, ValidD}, 32'd0);
    next(0, 0, 0, 0); chk_req("c24", 32'h4); chk_d("c24_top", 32'hFFFF_FFFC);
    next(0, 0, 0, 0); chk_req("c25", 32'h8); chk_d("c25", 32'h0);
    lat = 3;

    // Asynchronous reset while a request is outstanding.
    next(0, 0, 0, 0); chk("c26_req", {31'd0, imem_req}, 32'd0); chk_d("c26", 32'h4);
    #2; rst = 1'b1;
    #1; chk_reset("async_rst");
    lat = 1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk_req("r0", 32'h0);
    next(0, 0, 0, 0); chk_req("r1", 32'h4);
    next(0, 0, 0, 0); chk_d("r2", 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
